// File: rtl/multicycle_sequencer.sv
// Multicycle RV32 control sequencer: fetch/decode/execute/mem/wb with
// handshake timeouts, a sticky trap state and a retired-instruction count.
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int RETIRE_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7b5,
   input  logic                alu_zero,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                ir_we,
   output logic                pc_we,
   output logic                pc_src,
   output logic                reg_write,
   output logic                result_src,
   output logic                alu_src_b,
   output logic [3:0]          alu_control,
   output logic [2:0]          state_o,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [7:0]    wait_q, wait_d;
   logic [1:0]    cause_q, cause_d;
   logic [6:0]    op_q;
   logic [2:0]    f3_q;
   logic          f7_q;
   logic          latch_en;
   logic          retire_en;
   logic [RETIRE_W-1:0] retired_q;

   logic is_r, is_i, is_ld, is_st, is_br, legal_in;
   logic [3:0] exec_alu;

   assign is_r  = (op_q == OP_R);
   assign is_i  = (op_q == OP_I);
   assign is_ld = (op_q == OP_LD);
   assign is_st = (op_q == OP_ST);
   assign is_br = (op_q == OP_BR);

   assign legal_in = (opcode == OP_R) || (opcode == OP_I) ||
                     (opcode == OP_LD) || (opcode == OP_ST) ||
                     (opcode == OP_BR);

   // funct7b5 selects SUB only for register-register ops
   always_comb begin
      exec_alu = ALU_ADD;
      if (is_br) begin
         exec_alu = ALU_SUB;
      end else if (is_r || is_i) begin
         case (f3_q)
            3'b000:  exec_alu = (is_r && f7_q) ? ALU_SUB : ALU_ADD;
            3'b010:  exec_alu = ALU_SLT;
            3'b110:  exec_alu = ALU_OR;
            3'b111:  exec_alu = ALU_AND;
            default: exec_alu = ALU_ADD;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      cause_d     = cause_q;
      latch_en    = 1'b0;
      retire_en   = 1'b0;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 1'b0;
      reg_write   = 1'b0;
      result_src  = 1'b0;
      alu_src_b   = 1'b0;
      alu_control = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end else if (wait_q == TO_LAST) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            latch_en = 1'b1;
            if (legal_in) begin
               state_d = S_EXECUTE;
            end else begin
               state_d = S_TRAP;
               cause_d = 2'b01;
            end
         end
         S_EXECUTE: begin
            alu_control = exec_alu;
            alu_src_b   = is_i || is_ld || is_st;
            if (is_r || is_i) begin
               state_d = S_WB;
            end else if (is_ld || is_st) begin
               state_d = S_MEM;
               wait_d  = 8'd0;
            end else if (is_br) begin
               pc_we     = alu_zero;
               pc_src    = alu_zero;
               retire_en = 1'b1;
               state_d   = S_FETCH;
               wait_d    = 8'd0;
            end else begin
               state_d = S_TRAP;
               cause_d = 2'b01;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_st;
            if (dmem_ready) begin
               wait_d = 8'd0;
               if (is_st) begin
                  retire_en = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == TO_LAST) begin
               state_d = S_TRAP;
               cause_d = 2'b11;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            result_src = is_ld;
            retire_en  = 1'b1;
            state_d    = S_FETCH;
            wait_d     = 8'd0;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
         end
      endcase
      // reset silences every strobe immediately, not at the next edge
      if (!rst_n) begin
         imem_req    = 1'b0;
         dmem_req    = 1'b0;
         dmem_we     = 1'b0;
         ir_we       = 1'b0;
         pc_we       = 1'b0;
         pc_src      = 1'b0;
         reg_write   = 1'b0;
         result_src  = 1'b0;
         alu_src_b   = 1'b0;
         alu_control = ALU_ADD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         wait_q    <= 8'd0;
         cause_q   <= 2'b00;
         op_q      <= 7'd0;
         f3_q      <= 3'd0;
         f7_q      <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
         if (latch_en) begin
            op_q <= opcode;
            f3_q <= funct3;
            f7_q <= funct7b5;
         end
         if (retire_en) begin
            retired_q <= retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign state_o    = state_q;
   assign trap       = rst_n && (state_q == S_TRAP);
   assign trap_cause = cause_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scenario bench for multicycle_sequencer: expected decode results are
// queued per instruction and checked when the sequencer reaches EXECUTE.
module tb_multicycle_sequencer;

   localparam int TO = 15;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0001;
   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SUB = 4'b0110;
   localparam logic [3:0] A_SLT = 4'b0111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7b5 = 1'b0;
   logic        alu_zero = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src;
   logic        reg_write, result_src, alu_src_b, trap;
   logic [3:0]  alu_control;
   logic [2:0]  state_o;
   logic [1:0]  trap_cause;
   logic [31:0] retired;

   typedef struct packed {
      logic [3:0] alu;
      logic       srcb;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] ret_exp = '0;

   multicycle_sequencer #(.MEM_TIMEOUT(TO), .RETIRE_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .alu_zero(alu_zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .reg_write(reg_write), .result_src(result_src),
      .alu_src_b(alu_src_b), .alu_control(alu_control),
      .state_o(state_o), .trap(trap), .trap_cause(trap_cause),
      .retired(retired)
   );

   always #5 clk = ~clk;

   // iwait/dwait < 0 means the memory never answers
   task automatic run_instr(input string nm, input logic [6:0] op,
                            input logic [2:0] f3, input logic f7,
                            input logic z, input int iwait,
                            input int dwait, input logic [3:0] alu,
                            input logic srcb, input logic noise);
      logic ld, st, br, legal, rdy;
      logic [47:0] g, w;
      exp_t e;
      int n;
      ld = (op == OP_LD);
      st = (op == OP_ST);
      br = (op == OP_BR);
      legal = ld || st || br || op == OP_R || op == OP_I;
      if (legal && iwait >= 0) sb.push_back({alu, srcb});
      opcode = op; funct3 = f3; funct7b5 = f7; alu_zero = z;
      dmem_ready = noise;
      n = (iwait < 0) ? TO : iwait + 1;
      for (int i = 0; i < n; i++) begin
         rdy = (i == iwait);
         imem_ready = rdy;
         #1;
         g = {state_o, imem_req, ir_we, pc_we, pc_src, dmem_req};
         w = {3'd0, 1'b1, rdy, rdy, 1'b0, 1'b0};
         total++;
         if (g !== w) begin
            bad++;
            $display("FAIL %s fetch%0d got=%b want=%b", nm, i, g, w);
         end
         @(negedge clk);
      end
      imem_ready = noise;
      if (iwait < 0) begin
         #1;
         g = {state_o, trap, trap_cause, imem_req, ir_we};
         w = {3'd5, 1'b1, 2'b10, 1'b0, 1'b0};
         total++;
         if (g !== w) begin
            bad++;
            $display("FAIL %s itimeout got=%b want=%b", nm, g, w);
         end
         imem_ready = 1'b0; dmem_ready = 1'b0;
         return;
      end
      #1;
      g = {state_o, imem_req, ir_we, pc_we, reg_write, dmem_req, alu_control};
      w = {3'd1, 5'b0, A_ADD};
      total++;
      if (g !== w) begin
         bad++;
         $display("FAIL %s decode got=%b want=%b", nm, g, w);
      end
      @(negedge clk);
      if (!legal) begin
         #1;
         g = {state_o, trap, trap_cause, imem_req, ir_we};
         w = {3'd5, 1'b1, 2'b01, 1'b0, 1'b0};
         total++;
         if (g !== w) begin
            bad++;
            $display("FAIL %s illegal got=%b want=%b", nm, g, w);
         end
         imem_ready = 1'b0; dmem_ready = 1'b0;
         return;
      end
      e = sb.pop_front();
      #1;
      g = {state_o, alu_control, alu_src_b, pc_we, pc_src,
           reg_write, dmem_req, imem_req};
      w = {3'd2, e.alu, e.srcb, br & z, br & z, 3'b000};
      total++;
      if (g !== w) begin
         bad++;
         $display("FAIL %s execute got=%b want=%b", nm, g, w);
      end
      @(negedge clk);
      if (ld || st) begin
         n = (dwait < 0) ? TO : dwait + 1;
         for (int i = 0; i < n; i++) begin
            dmem_ready = (i == dwait);
            #1;
            g = {state_o, dmem_req, dmem_we, reg_write, imem_req, alu_control};
            w = {3'd3, 1'b1, st, 2'b00, A_ADD};
            total++;
            if (g !== w) begin
               bad++;
               $display("FAIL %s mem%0d got=%b want=%b", nm, i, g, w);
            end
            @(negedge clk);
         end
         dmem_ready = noise;
         if (dwait < 0) begin
            #1;
            g = {state_o, trap, trap_cause, dmem_req, dmem_we, retired};
            w = {3'd5, 1'b1, 2'b11, 2'b00, ret_exp};
            total++;
            if (g !== w) begin
               bad++;
               $display("FAIL %s dtimeout got=%b want=%b", nm, g, w);
            end
            imem_ready = 1'b0; dmem_ready = 1'b0;
            return;
         end
      end
      if (!st && !br) begin
         #1;
         g = {state_o, reg_write, result_src, imem_req, dmem_req, alu_control};
         w = {3'd4, 1'b1, ld, 2'b00, A_ADD};
         total++;
         if (g !== w) begin
            bad++;
            $display("FAIL %s wb got=%b want=%b", nm, g, w);
         end
         @(negedge clk);
      end
      ret_exp = ret_exp + 32'd1;
      #1;
      g = {state_o, trap, retired};
      w = {3'd0, 1'b0, ret_exp};
      total++;
      if (g !== w) begin
         bad++;
         $display("FAIL %s retire got=%b want=%b", nm, g, w);
      end
      imem_ready = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      logic [47:0] g, w;
      rst_n = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      #1;
      g = {state_o, imem_req, dmem_req, ir_we, pc_we, reg_write,
           trap, trap_cause, retired};
      w = {3'd0, 5'b0, 1'b0, 2'b00, 32'd0};
      total++;
      if (g !== w) begin
         bad++;
         $display("FAIL %s in_reset got=%b want=%b", nm, g, w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ret_exp = '0;
      sb.delete();
      #1;
      total++;
      if ({state_o, imem_req} !== {3'd0, 1'b1}) begin
         bad++;
         $display("FAIL %s release got=%b want=0001", nm, {state_o, imem_req});
      end
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_r_add();
      run_instr("r_add", OP_R, 3'b000, 1'b0, 1'b0, 2, 0, A_ADD, 1'b0, 1'b0);
   endtask

   task automatic test_alu_ops();
      run_instr("r_sub", OP_R, 3'b000, 1'b1, 1'b0, 0, 0, A_SUB, 1'b0, 1'b0);
      run_instr("i_add7", OP_I, 3'b000, 1'b1, 1'b0, 1, 0, A_ADD, 1'b1, 1'b0);
      run_instr("r_slt", OP_R, 3'b010, 1'b0, 1'b0, 0, 0, A_SLT, 1'b0, 1'b0);
      run_instr("i_slt", OP_I, 3'b010, 1'b0, 1'b0, 0, 0, A_SLT, 1'b1, 1'b0);
      run_instr("r_or", OP_R, 3'b110, 1'b0, 1'b0, 0, 0, A_OR, 1'b0, 1'b0);
      run_instr("i_and", OP_I, 3'b111, 1'b0, 1'b0, 0, 0, A_AND, 1'b1, 1'b0);
      run_instr("r_and7", OP_R, 3'b111, 1'b1, 1'b0, 0, 0, A_AND, 1'b0, 1'b0);
      run_instr("r_f3oth", OP_R, 3'b001, 1'b1, 1'b0, 0, 0, A_ADD, 1'b0, 1'b0);
      run_instr("i_f3oth", OP_I, 3'b101, 1'b0, 1'b0, 0, 0, A_ADD, 1'b1, 1'b0);
   endtask

   task automatic test_load();
      run_instr("load", OP_LD, 3'b010, 1'b1, 1'b0, 0, 4, A_ADD, 1'b1, 1'b0);
   endtask

   task automatic test_store();
      run_instr("store", OP_ST, 3'b010, 1'b0, 1'b0, 1, 0, A_ADD, 1'b1, 1'b0);
      run_instr("store_edge", OP_ST, 3'b010, 1'b0, 1'b0, 0, TO - 1,
                A_ADD, 1'b1, 1'b0);
   endtask

   task automatic test_branch();
      run_instr("beq_taken", OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, A_SUB, 1'b0, 1'b0);
      run_instr("beq_not", OP_BR, 3'b001, 1'b1, 1'b0, 0, 0, A_SUB, 1'b0, 1'b0);
   endtask

   task automatic test_ready_ignored();
      run_instr("noise_r", OP_R, 3'b110, 1'b0, 1'b0, 1, 0, A_OR, 1'b0, 1'b1);
      run_instr("noise_ld", OP_LD, 3'b000, 1'b0, 1'b0, 0, 2, A_ADD, 1'b1, 1'b1);
      run_instr("noise_br", OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, A_SUB, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [6];
      logic [3:0] alus [6];
      logic       srcs [6];
      ops  = '{OP_R, OP_ST, OP_LD, OP_BR, OP_I, OP_R};
      alus = '{A_ADD, A_ADD, A_ADD, A_SUB, A_ADD, A_ADD};
      srcs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         run_instr("b2b", ops[i], 3'b000, 1'b0, 1'b0, 0, 0,
                   alus[i], srcs[i], 1'b0);
      end
   endtask

   task automatic test_fetch_edge();
      run_instr("fetch_edge", OP_I, 3'b110, 1'b0, 1'b0, TO - 1, 0,
                A_OR, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_mem();
      logic [47:0] g, w;
      opcode = OP_LD; funct3 = 3'b000; funct7b5 = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2;
      total++;
      if ({state_o, dmem_req} !== {3'd3, 1'b1}) begin
         bad++;
         $display("FAIL rst_mem pre got=%b want=0111", {state_o, dmem_req});
      end
      rst_n = 1'b0;
      #1;
      g = {state_o, imem_req, dmem_req, dmem_we, reg_write, trap, retired};
      w = {3'd0, 5'b0, 32'd0};
      total++;
      if (g !== w) begin
         bad++;
         $display("FAIL rst_mem async got=%b want=%b", g, w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ret_exp = '0;
      #1;
      total++;
      if ({state_o, imem_req, dmem_req} !== {3'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL rst_mem refetch got=%b want=00010",
                  {state_o, imem_req, dmem_req});
      end
   endtask

   task automatic test_illegal();
      logic [47:0] g, w;
      run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0,
                A_ADD, 1'b0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         imem_ready = 1'($urandom_range(0, 1));
         dmem_ready = 1'($urandom_range(0, 1));
         alu_zero = 1'($urandom_range(0, 1));
         #1;
         g = {state_o, trap, trap_cause, imem_req, dmem_req, ir_we,
              pc_we, reg_write, alu_control, retired};
         w = {3'd5, 1'b1, 2'b01, 5'b0, A_ADD, ret_exp};
         total++;
         if (g !== w) begin
            bad++;
            $display("FAIL illegal_hold%0d got=%b want=%b", i, g, w);
         end
         @(negedge clk);
      end
      do_reset("illegal_rst");
   endtask

   task automatic test_dmem_timeout();
      run_instr("dtimeout", OP_ST, 3'b010, 1'b0, 1'b0, 0, -1,
                A_ADD, 1'b1, 1'b0);
      do_reset("dtimeout_rst");
   endtask

   task automatic test_imem_timeout();
      run_instr("itimeout", OP_R, 3'b000, 1'b0, 1'b0, -1, 0,
                A_ADD, 1'b0, 1'b0);
      do_reset("itimeout_rst");
   endtask

   initial begin
      test_reset();
      test_r_add();
      test_alu_ops();
      test_load();
      test_store();
      test_branch();
      test_ready_ignored();
      test_back_to_back();
      test_fetch_edge();
      test_reset_mid_mem();
      test_r_add();
      test_illegal();
      test_dmem_timeout();
      test_imem_timeout();
      test_r_add();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max wait cycles for a memory handshake before trap (range 1..255).
REQ-002 Parameter: RETIRE_W, 32, width of retired-instruction counter.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: opcode  input  7  instruction opcode from instruction register; valid from DECODE onward.
REQ-006 Port: funct3  input  3  instruction funct3; funct7b5  input  1  instruction bit 30.
REQ-007 Port: alu_zero  input  1  ALU zero flag, valid in EXECUTE.
REQ-008 Port: imem_ready  input  1  instruction memory ack; dmem_ready  input  1  data memory ack.
REQ-009 Port: imem_req  output  1  instruction fetch request; dmem_req  output  1  data access request; dmem_we  output  1  data write enable.
REQ-010 Port: ir_we, pc_we, pc_src  output  1 each  IR load, PC load, PC source (0 = PC+4, 1 = branch target).
REQ-011 Port: reg_write  output  1  register-file write enable; result_src  output  1  (0 = ALU, 1 = load data); alu_src_b  output  1  (0 = rs2, 1 = immediate).
REQ-012 Port: alu_control  output  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
REQ-013 Port: state_o  output  3  current state encoding; trap  output  1  sticky fault; trap_cause  output  2  (01 illegal opcode, 10 imem timeout, 11 dmem timeout).
REQ-014 Port: retired  output  RETIRE_W  count of completed instructions.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; encodings 6-7 SHALL go to TRAP with cause 01.
REQ-016 FETCH: imem_req=1 held until imem_ready; on imem_ready: ir_we=1, pc_we=1, pc_src=0, next DECODE; otherwise stay.
REQ-017 DECODE (1 cycle): opcode, funct3, funct7b5 latched internally; supported opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH); any other -> TRAP, cause 01.
REQ-018 EXECUTE (1 cycle), uses latched fields only: R/I-ALU -> WB; LOAD/STORE -> MEM; BRANCH -> FETCH.
REQ-019 alu_control in EXECUTE: R funct3 000 ADD, or SUB if funct7b5=1; I-ALU funct3 000 ADD always; funct3 010 SLT, 110 OR, 111 AND; other funct3 SHALL give ADD; LOAD/STORE ADD; BRANCH SUB.
REQ-020 alu_src_b=1 in EXECUTE for I-ALU, LOAD, STORE; 0 otherwise.
REQ-021 BRANCH (beq only, funct3 ignored): in EXECUTE pc_we=1, pc_src=1 when alu_zero=1; no PC write when alu_zero=0.
REQ-022 MEM: dmem_req=1, dmem_we=1 for STORE only, held until dmem_ready; on ready LOAD -> WB, STORE -> FETCH.
REQ-023 WB (1 cycle): reg_write=1; result_src=1 for LOAD, 0 for R/I-ALU; next FETCH.
REQ-024 Wait counter: cleared on entry to FETCH or MEM, +1 each cycle ready low; when MEM_TIMEOUT cycles elapse without ready -> TRAP, cause 10 (FETCH) or 11 (MEM).
REQ-025 Ready asserted in the same cycle the counter reaches MEM_TIMEOUT SHALL count as success (handshake wins).
REQ-026 TRAP: all enables and requests 0, trap=1, cause held; exit only via reset.
REQ-027 retired +1 on the cycle leaving WB, MEM for STORE, or EXECUTE for BRANCH; wraps to 0 past 2^RETIRE_W-1.
REQ-028 All outputs not asserted by a rule above SHALL be 0; alu_control outside EXECUTE SHALL be ADD (0010).
REQ-029 Ready inputs SHALL be ignored outside the state that requests them.

Reset
REQ-030 rst_n low SHALL immediately force state FETCH, wait counter 0, retired 0, trap 0, trap_cause 00, latched fields 0, all enables 0.
REQ-031 Reset mid-MEM or mid-FETCH SHALL abandon the access; first request re-issued first cycle after rst_n rises.

Verification
REQ-032 R-type ADD opcode 0110011, funct7b5=0, imem_ready after 2 cycles -> FETCH 3 cycles, DECODE, EXECUTE alu_control=0010, WB reg_write=1, retired 0->1.
REQ-033 LOAD with dmem_ready delayed 4 cycles -> dmem_req high 5 cycles, dmem_we=0, WB result_src=1, retired +1.
REQ-034 BRANCH with alu_zero=1 -> EXECUTE pc_we=1, pc_src=1, alu_control=0110, next FETCH; repeat with alu_zero=0 -> pc_we=0.
REQ-035 Opcode 1111111 -> TRAP after DECODE, trap=1, trap_cause=01, stays there 100 cycles with imem_req=0.
REQ-036 STORE with dmem_ready never asserted, MEM_TIMEOUT=15 -> TRAP after 15 MEM cycles, cause 11; dmem_ready in the 15th cycle instead -> FETCH, no trap.
REQ-037 rst_n pulsed low during MEM -> outputs 0 asynchronously, retired=0, imem_req=1 first cycle after release.
